apb_slave_mem: RTL

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_mem_array.sv | 42 ++++
 rtl/apb_slave_mem.sv | 133 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB slave memory: FSM states, default widths
// and the address error check used by the slave decode.
package apb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 32;

    // A byte address is bad when it is not word aligned or its word index
    // lies beyond the storage depth.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Word storage for the APB slave: synchronous write, registered read,
// whole array cleared on reset.
module apb_mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage update: reset clears every word, otherwise one word per write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read register: loads only when asked, holding its value otherwise;
    // an erroneous read loads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_idx];
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with internal word memory, programmable wait states and
// error response for misaligned or out-of-range addresses.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic        NO_WAIT   = (WAIT_CYCLES == 0);

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic              ready_q;
    logic              slverr_q;

    logic              setup;
    logic              cur_err;
    logic              wr_en;
    logic              rd_en;
    logic              rd_zero;
    logic [IDX_W-1:0]  rd_idx;

    // Setup detection, error decode and memory port control. With no wait
    // states PREADY rises on the setup edge itself, so the read register
    // must load from the live PADDR instead of the latched one.
    always_comb begin
        setup   = (state == ST_IDLE) && PSEL && !PENABLE;
        cur_err = addr_err(32'(PADDR), DEPTH);
        wr_en   = (state == ST_ACCESS) && PSEL && PENABLE && ready_q && write_q && !err_q;
        rd_en   = 1'b0;
        rd_zero = err_q;
        rd_idx  = addr_q[IDX_W+1:2];
        if (setup) begin
            rd_en   = NO_WAIT && !PWRITE;
            rd_zero = cur_err;
            rd_idx  = PADDR[IDX_W+1:2];
        end else if ((state == ST_ACCESS) && PSEL && (cnt == 4'd1)) begin
            rd_en   = !write_q;
        end
    end

    // Transfer FSM with wait counter and registered PREADY/PSLVERR.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_q  <= 1'b0;
                    slverr_q <= 1'b0;
                    if (setup) begin
                        state    <= ST_ACCESS;
                        addr_q   <= PADDR;
                        write_q  <= PWRITE;
                        wdata_q  <= PWDATA;
                        err_q    <= cur_err;
                        cnt      <= WAIT_INIT;
                        ready_q  <= NO_WAIT;
                        slverr_q <= NO_WAIT && cur_err;
                    end
                end
                ST_ACCESS: begin
                    if (!PSEL) begin
                        state    <= ST_IDLE;
                        cnt      <= '0;
                        ready_q  <= 1'b0;
                        slverr_q <= 1'b0;
                    end else if (ready_q && PENABLE) begin
                        state    <= ST_IDLE;
                        ready_q  <= 1'b0;
                        slverr_q <= 1'b0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            ready_q  <= 1'b1;
                            slverr_q <= err_q;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign PREADY  = ready_q;
    assign PSLVERR = slverr_q;

    apb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk     (PCLK),
        .rst     (PRESET),
        .wr_en   (wr_en),
        .wr_idx  (addr_q[IDX_W+1:2]),
        .wr_data (wdata_q),
        .rd_en   (rd_en),
        .rd_zero (rd_zero),
        .rd_idx  (rd_idx),
        .rd_data (PRDATA)
    );

endmodule
